// File: rtl/aes_round_unit.sv
// Registered single-round AES-128 datapath: initial, full or final round of one state/key pair.
// Defining AES_ROUND_PIPE_EN adds a register stage after SubBytes, which makes the latency 2 cycles.
module aes_round_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [1:0]   round_type,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic         out_valid,
  output logic [127:0] state_out
);

  localparam logic [1:0] TYPE_INITIAL = 2'd0;
  localparam logic [1:0] TYPE_FINAL   = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Inverse as a^254 through a short addition chain; 0x00 maps to 0x00 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      res[127-8*k -: 8] = sbox(st[127-8*k -: 8]);
    end
    return res;
  endfunction

  // Byte 4c+r holds s[r][c]; row r takes its bytes from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] st);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  logic [127:0] sb_state;
  logic [127:0] front_state;

  assign sb_state    = sub_bytes(state_in);
  assign front_state = (round_type == TYPE_INITIAL) ? state_in : sb_state;

  logic         back_valid;
  logic [1:0]   back_type;
  logic [127:0] back_state;
  logic [127:0] back_key;

`ifdef AES_ROUND_PIPE_EN
  logic         mid_valid;
  logic [1:0]   mid_type;
  logic [127:0] mid_state;
  logic [127:0] mid_key;

  // Round type and key ride along with the substituted state so the back half sees a consistent set.
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_valid <= 1'b0;
      mid_type  <= 2'd0;
      mid_state <= '0;
      mid_key   <= '0;
    end else begin
      mid_valid <= in_valid;
      if (in_valid) begin
        mid_type  <= round_type;
        mid_state <= front_state;
        mid_key   <= round_key;
      end
    end
  end

  assign back_valid = mid_valid;
  assign back_type  = mid_type;
  assign back_state = mid_state;
  assign back_key   = mid_key;
`else
  assign back_valid = in_valid;
  assign back_type  = round_type;
  assign back_state = front_state;
  assign back_key   = round_key;
`endif

  logic [127:0] sr_state;
  logic [127:0] mc_state;
  logic [127:0] pre_key;

  assign sr_state = shift_rows(back_state);
  assign mc_state = mix_columns(sr_state);

  // Round type 3 falls into the default branch and behaves as a full round.
  always_comb begin
    pre_key = mc_state;
    case (back_type)
      TYPE_INITIAL: pre_key = back_state;
      TYPE_FINAL:   pre_key = sr_state;
      default:      pre_key = mc_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      state_out <= '0;
    end else begin
      out_valid <= back_valid;
      if (back_valid) state_out <= pre_key ^ back_key;
    end
  end

endmodule

// File: tb/tb_aes_round_unit.sv
// Directed bench for aes_round_unit: table-driven round model checked every cycle, plus FIPS-197 literals.
module tb_aes_round_unit;

`ifdef AES_ROUND_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   round_type;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic [127:0] state_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_round_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .round_type (round_type),
    .state_in   (state_in),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .state_out  (state_out)
  );

  logic [7:0]    sbox_tab [256];
  logic [2047:0] sbox_flat;

  initial begin
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_flat[2047-8*i -: 8];
  end

  function automatic logic [7:0] dbl(input logic [7:0] a);
    logic [8:0] w;
    w = {a, 1'b0};
    if (w[8]) w = w ^ 9'h11b;
    return w[7:0];
  endfunction

  // Works on a 4x4 byte matrix s[row][col], the textbook view of the state.
  function automatic logic [127:0] model_round(input logic [1:0] t, input logic [127:0] st,
                                               input logic [127:0] key);
    logic [7:0]   s [4][4];
    logic [7:0]   u [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = st[127-8*(4*c+r) -: 8];
    if (t != 2'd0) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[r][c] = sbox_tab[s[r][(c+r)%4]];
      s = u;
      if (t != 2'd2) begin
        for (int c = 0; c < 4; c++) begin
          s[0][c] = dbl(u[0][c]) ^ dbl(u[1][c]) ^ u[1][c] ^ u[2][c] ^ u[3][c];
          s[1][c] = u[0][c] ^ dbl(u[1][c]) ^ dbl(u[2][c]) ^ u[2][c] ^ u[3][c];
          s[2][c] = u[0][c] ^ u[1][c] ^ dbl(u[2][c]) ^ dbl(u[3][c]) ^ u[3][c];
          s[3][c] = dbl(u[0][c]) ^ u[0][c] ^ u[1][c] ^ u[2][c] ^ dbl(u[3][c]);
        end
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res ^ key;
  endfunction

  logic         model_ready = 1'b0;
  logic         exp_valid;
  logic [127:0] exp_state;
  logic         sh_v [LAT];
  logic [127:0] sh_d [LAT];

  // Model advances on each rising edge; outputs are compared on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < LAT; i++) begin
          sh_v[i] = 1'b0;
          sh_d[i] = '0;
        end
        exp_valid   = 1'b0;
        exp_state   = '0;
        model_ready = 1'b1;
      end else if (model_ready) begin
        for (int i = LAT - 1; i > 0; i--) begin
          sh_v[i] = sh_v[i-1];
          sh_d[i] = sh_d[i-1];
        end
        sh_v[0] = in_valid;
        sh_d[0] = model_round(round_type, state_in, round_key);
        exp_valid = sh_v[LAT-1];
        if (sh_v[LAT-1]) exp_state = sh_d[LAT-1];
      end
      @(negedge clk);
      if (model_ready) begin
        n_vec++;
        if (out_valid !== exp_valid) begin
          n_err++;
          $display("[TB] FAIL out_valid @%0t: got %b, expected %b", $time, out_valid, exp_valid);
        end
        n_vec++;
        if (state_out !== exp_state) begin
          n_err++;
          $display("[TB] FAIL state_out @%0t: got %h, expected %h", $time, state_out, exp_state);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] t, input logic [127:0] st, input logic [127:0] key);
    in_valid   = 1'b1;
    round_type = t;
    state_in   = st;
    round_key  = key;
    @(negedge clk);
  endtask

  task automatic check_value(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic check_output(input string name, input logic [127:0] want);
    int waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s: got no out_valid within 8 cycles, expected %h", name, want);
    end else if (state_out !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, state_out, want);
    end
  endtask

  task automatic run_one(input string name, input logic [1:0] t, input logic [127:0] st,
                         input logic [127:0] key, input logic [127:0] want);
    apply_stimulus(t, st, key);
    in_valid = 1'b0;
    check_output(name, want);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] v;
    rst        = 1'b1;
    in_valid   = 1'b0;
    round_type = 2'd0;
    state_in   = '0;
    round_key  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_value("reset out_valid", {127'd0, out_valid}, 128'd0);
    check_value("reset state_out", state_out, 128'd0);

    run_one("initial round", 2'd0, 128'h3243f6a8885a308d313198a2e0370734,
            128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    run_one("full round", 2'd1, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
            128'ha0fafe1788542cb123a339392a6c7605, 128'ha49c7ff2689f352b6b5bea43026a5049);
    run_one("type3 round", 2'd3, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
            128'ha0fafe1788542cb123a339392a6c7605, 128'ha49c7ff2689f352b6b5bea43026a5049);
    run_one("final round", 2'd2, 128'heb40f21e592e38848ba113e71bc342d2,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h3925841d02dc09fbdc118597196a0b32);

    repeat (5) @(negedge clk);
    check_value("idle out_valid", {127'd0, out_valid}, 128'd0);
    check_value("idle state_out", state_out, 128'h3925841d02dc09fbdc118597196a0b32);

    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      apply_stimulus(2'd2, {16{v}}, 128'd0);
    end
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    run_one("sbox 00", 2'd2, {16{8'h00}}, 128'd0, {16{8'h63}});
    run_one("sbox 53", 2'd2, {16{8'h53}}, 128'd0, {16{8'hed}});
    run_one("sbox ff", 2'd2, {16{8'hff}}, 128'd0, {16{8'h16}});

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(i[1:0], {$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom});
    end
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    apply_stimulus(2'd1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    apply_stimulus(2'd2, 128'h0f0e0d0c0b0a09080706050403020100, 128'hffeeddccbbaa99887766554433221100);
    apply_stimulus(2'd0, 128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210);
    rst = 1'b1;
    apply_stimulus(2'd1, 128'h55555555555555555555555555555555, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_value("post-reset out_valid", {127'd0, out_valid}, 128'd0);
    check_value("post-reset state_out", state_out, 128'd0);
    repeat (3) @(negedge clk);
    check_value("post-reset idle state_out", state_out, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
